// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the two-requester shared ALU: data width,
// opcode encodings and the controller state enumeration.
package alu_share_arb_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] OP_ROL = 4'd0;
  localparam logic [3:0] OP_ROR = 4'd1;
  localparam logic [3:0] OP_MAX = 4'd2;
  localparam logic [3:0] OP_MIN = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_MUL = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MULW = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/alu_share_arb_alu_core.sv
// Purely combinational ALU datapath shared by both requesters.
// Opcodes outside ROL..MUL yield a zero result with the illegal flag set.
module alu_core
  import alu_share_arb_pkg::*;
(
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [4:0]        shift_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              illegal_o
);

  logic [DATA_W-1:0] rol_s;
  logic [DATA_W-1:0] ror_s;
  logic [DATA_W:0]   sum_s;
  logic [5:0]        inv_shift_s;

  // A 32-bit shift of a 32-bit value yields zero, so shift 0 leaves a unchanged.
  assign inv_shift_s = 6'd32 - {1'b0, shift_i};
  assign rol_s       = (a_i << shift_i) | (a_i >> inv_shift_s);
  assign ror_s       = (a_i >> shift_i) | (a_i << inv_shift_s);
  assign sum_s       = {1'b0, a_i} + {1'b0, b_i};

  // Opcode decode and result selection.
  always_comb begin
    result_o  = '0;
    carry_o   = 1'b0;
    illegal_o = 1'b0;
    case (op_i)
      OP_ROL: result_o = rol_s;
      OP_ROR: result_o = ror_s;
      OP_MAX: result_o = (a_i >= b_i) ? a_i : b_i;
      OP_MIN: result_o = (a_i <= b_i) ? a_i : b_i;
      OP_ADD: begin
        result_o = sum_s[DATA_W-1:0];
        carry_o  = sum_s[DATA_W];
      end
      OP_MUL: result_o = a_i * b_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Two-requester round-robin front end and controller for a shared ALU.
// One operation is in flight at a time; the response is held until taken.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [4:0]        req0_shift,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [4:0]        req1_shift,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_illegal,
  output logic              busy
);

  localparam logic [3:0] MUL_WAIT = 4'(MUL_LAT - 1);

  state_t            state_q;
  logic              ptr_q;        // requester favoured on a tie
  logic [3:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [4:0]        shift_q;
  logic              id_q;
  logic [3:0]        cnt_q;
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_carry_q;
  logic              rsp_illegal_q;
  logic              busy_q;

  logic              grant0_d;
  logic              grant1_d;
  logic [3:0]        op_sel_d;
  logic [DATA_W-1:0] alu_result_s;
  logic              alu_carry_s;
  logic              alu_illegal_s;

  // Round-robin grant: only in IDLE and out of reset; a tie goes to ptr_q.
  always_comb begin
    grant0_d = 1'b0;
    grant1_d = 1'b0;
    if (!rst && (state_q == ST_IDLE)) begin
      grant0_d = req0_valid && (!req1_valid || !ptr_q);
      grant1_d = req1_valid && (!req0_valid ||  ptr_q);
    end else begin
      grant0_d = 1'b0;
      grant1_d = 1'b0;
    end
  end

  assign op_sel_d   = grant1_d ? req1_opcode : req0_opcode;
  assign req0_ready = grant0_d;
  assign req1_ready = grant1_d;

  alu_core u_alu_core (
    .op_i      (op_q),
    .a_i       (a_q),
    .b_i       (b_q),
    .shift_i   (shift_q),
    .result_o  (alu_result_s),
    .carry_o   (alu_carry_s),
    .illegal_o (alu_illegal_s)
  );

  // Controller FSM: capture on accept, optional multiply wait, compute, hold response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= 1'b0;
      op_q          <= 4'd0;
      a_q           <= '0;
      b_q           <= '0;
      shift_q       <= 5'd0;
      id_q          <= 1'b0;
      cnt_q         <= 4'd0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_result_q  <= '0;
      rsp_carry_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant0_d || grant1_d) begin
            op_q    <= op_sel_d;
            a_q     <= grant1_d ? req1_a     : req0_a;
            b_q     <= grant1_d ? req1_b     : req0_b;
            shift_q <= grant1_d ? req1_shift : req0_shift;
            id_q    <= grant1_d;
            ptr_q   <= !grant1_d;
            busy_q  <= 1'b1;
            if ((op_sel_d == OP_MUL) && (MUL_LAT > 1)) begin
              cnt_q   <= MUL_WAIT;
              state_q <= ST_MULW;
            end else begin
              state_q <= ST_EXEC;
            end
          end
        end
        ST_MULW: begin
          if (cnt_q <= 4'd1) begin
            cnt_q   <= 4'd0;
            state_q <= ST_EXEC;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
          end
        end
        ST_EXEC: begin
          rsp_result_q  <= alu_result_s;
          rsp_carry_q   <= alu_carry_s;
          rsp_illegal_q <= alu_illegal_s;
          rsp_id_q      <= id_q;
          rsp_valid_q   <= 1'b1;
          state_q       <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          cnt_q       <= 4'd0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_carry   = rsp_carry_q;
  assign rsp_illegal = rsp_illegal_q;
  assign busy        = busy_q;

endmodule
